rsa_result_axi_writer: RTL and testbench
========================================

Name: rsa_result_axi_writer

Overview:
- AXI4 write master that drains the RSA result FIFO (first-word-fall-through) into SRAM_INTERFACE as INCR write bursts.
- It is the write-direction counterpart of the RSA_TOP operand-fetch read master.
- Software supplies base address and word count through RSA_TOP control registers; the block splits the transfer into bursts of at most MAX_BURST beats that never cross a 4 KB boundary.
- Only one burst is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI/FIFO data width; only 32 is supported.
- CNT_WIDTH, 16, width of the total word-count input.
- MAX_BURST, 16, maximum beats per burst; legal range 1..256.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches base_addr and word_cnt when idle.
- base_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored and treated as 0.
- word_cnt  in  CNT_WIDTH  number of 32-bit words to write.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- err  out  1  sticky flag: some BRESP was not OKAY; cleared by the next accepted start.
- fifo_dout  in  DATA_WIDTH  result FIFO data; valid whenever fifo_empty=0 (FWFT).
- fifo_empty  in  1  result FIFO empty.
- fifo_rd_en  out  1  pop the result FIFO.
- M_AXI_AWID  out  4  write address ID; constant 0.
- M_AXI_AWADDR  out  ADDR_WIDTH  burst start address.
- M_AXI_AWLEN  out  8  burst beats minus 1.
- M_AXI_AWSIZE  out  3  constant 3'b010.
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR).
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  DATA_WIDTH  equals fifo_dout.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WLAST  out  1  marks the last beat of the burst.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BID  in  4  write response ID; ignored.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.

Behaviour:
- Clocking: single clock; rst is synchronous and active-high.
- Reset: state IDLE. busy, done, err, AWVALID, WVALID, WLAST, BREADY and fifo_rd_en are 0. AWADDR and AWLEN are 0. Internal address, remaining count and beat counters are 0.
- Reset mid-transfer: the block abandons the transfer immediately and drives no further AXI valids. The result FIFO is not flushed.
- State machine: IDLE, CALC, AW, W, B, DONE.
- IDLE:
  - start=1 latches addr=base_addr&~3 and rem=word_cnt, sets busy=1 and clears err.
  - If word_cnt==0, go to DONE; otherwise go to CALC.
  - start while busy is ignored.
- CALC (1 cycle):
  - len = min(rem, MAX_BURST, (4096 - addr[11:0])>>2).
  - AWADDR=addr, AWLEN=len-1.
  - Go to AW.
- AW:
  - AWVALID=1 and is held, with AWADDR/AWLEN stable, until AWREADY.
  - On handshake go to W. Data beats are never issued before the address handshake.
- W:
  - WVALID = !fifo_empty; WDATA = fifo_dout.
  - fifo_rd_en = WVALID & WREADY, so exactly one pop per accepted beat.
  - WLAST=1 when the beat counter equals len-1.
  - If the FIFO runs empty mid-burst, WVALID drops and resumes when data is present; no bubble beats are sent.
  - After the last accepted beat go to B.
- B:
  - BREADY=1.
  - On BVALID: err |= (BRESP != 2'b00); addr += len*4; rem -= len.
  - If rem==0 go to DONE, else go to CALC.
- DONE: done=1 for exactly one cycle; busy goes to 0 in the same cycle; go to IDLE.
- Latency: start to AWVALID is 2 cycles (IDLE→CALC→AW). The last BVALID handshake to done is 1 cycle.
- Error handling: an error response does not abort the transfer. All words are still written, and err reports the failure.
- Address wrap: addr arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow detection.
- AWLEN width: AWLEN is 8 bits, hence MAX_BURST ≤ 256.

Test Plan:
- Basic single burst: base=0x100, cnt=8, FIFO preloaded with 1..8, AWREADY/WREADY/BVALID always high. Expect one burst with AWADDR=0x100, AWLEN=7; WDATA 1..8 with WLAST on beat 8; done pulse; err=0; FIFO empty.
- Burst split: base=0x0, cnt=40, MAX_BURST=16. Expect three bursts: (0x000, AWLEN 15), (0x040, AWLEN 15), (0x080, AWLEN 7); exactly 40 pops.
- 4 KB boundary: base=0xFF8, cnt=6. Expect two bursts: (0xFF8, AWLEN 1) then (0x1000, AWLEN 3).
- Backpressure and underflow: random AWREADY, WREADY and BVALID delays, with the FIFO empty for 5 cycles mid-burst. Expect stable AW fields while AWVALID=1, no pop without a WREADY handshake, WVALID=0 while the FIFO is empty, and the data order preserved.
- Error and edge cases:
  - BRESP=2'b10 on the 2nd of 3 bursts: all bursts still complete, err=1 after done; the next start clears err.
  - cnt=0: done 1 cycle after start and no AWVALID.
  - start while busy: ignored.
- Reset mid-burst: assert rst during beat 3 of 8. Next cycle all valids are 0, busy=0 and the state is IDLE; a fresh start then runs correctly.

Source files
------------

// File: rtl/rsa_result_axi_writer_if.sv
// AXI4 write-channel bundle between the RSA result writer (master) and SRAM_INTERFACE (slave).
interface rsa_result_axi_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            M_AXI_AWID;
    logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [7:0]            M_AXI_AWLEN;
    logic [2:0]            M_AXI_AWSIZE;
    logic [1:0]            M_AXI_AWBURST;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] M_AXI_WDATA;
    logic [3:0]            M_AXI_WSTRB;
    logic                  M_AXI_WLAST;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [3:0]            M_AXI_BID;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/rsa_result_axi_writer.sv
// Drains the FWFT RSA result FIFO into memory as INCR AXI4 write bursts, one burst in flight,
// bursts capped at MAX_BURST beats and never crossing a 4 KB boundary.
module rsa_result_axi_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    rsa_result_axi_writer_if.master axi
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_AW   = 3'd2;
    localparam logic [2:0] ST_W    = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [CNT_WIDTH-1:0]  rem_q,    rem_d;
    logic [8:0]            len_q,    len_d;
    logic [7:0]            beat_q,   beat_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q,  awlen_d;
    logic                  err_q,    err_d;

    logic [8:0]            len_calc;
    logic [CNT_WIDTH-1:0]  rem_after;
    logic                  aw_hs, w_valid, w_hs, b_hs;
    logic                  unused_bid;

    // Burst length limited by words left, MAX_BURST and the room before the next 4 KB page.
    function automatic logic [8:0] calc_len(input logic [CNT_WIDTH-1:0] rem, input logic [11:0] off);
        logic [31:0] lim;
        logic [31:0] room;
        room = (32'd4096 - {20'd0, off}) >> 2;
        lim  = 32'(rem);
        if (lim > 32'(MAX_BURST)) lim = 32'(MAX_BURST);
        if (lim > room)           lim = room;
        return 9'(lim);
    endfunction

    assign len_calc  = calc_len(rem_q, addr_q[11:0]);
    assign rem_after = rem_q - CNT_WIDTH'(len_q);
    assign aw_hs     = (state_q == ST_AW) && axi.M_AXI_AWREADY;
    assign w_valid   = (state_q == ST_W) && !fifo_empty;
    assign w_hs      = w_valid && axi.M_AXI_WREADY;
    assign b_hs      = (state_q == ST_B) && axi.M_AXI_BVALID;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        len_d    = len_q;
        beat_d   = beat_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr & ~ADDR_WIDTH'(3);
                    rem_d   = word_cnt;
                    err_d   = 1'b0;
                    state_d = (word_cnt == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                len_d    = len_calc;
                awaddr_d = addr_q;
                awlen_d  = 8'(len_calc - 9'd1);
                beat_d   = 8'd0;
                state_d  = ST_AW;
            end
            ST_AW: begin
                if (aw_hs) state_d = ST_W;
            end
            ST_W: begin
                if (w_hs) begin
                    if (beat_q == awlen_q) begin
                        beat_d  = 8'd0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_B: begin
                // An error response is recorded but the transfer carries on.
                if (b_hs) begin
                    err_d   = err_q | (axi.M_AXI_BRESP != 2'b00);
                    addr_d  = addr_q + ADDR_WIDTH'({len_q, 2'b00});
                    rem_d   = rem_after;
                    state_d = (rem_after == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            err_q    <= err_d;
        end
    end

    assign busy       = (state_q == ST_CALC) || (state_q == ST_AW) ||
                        (state_q == ST_W)    || (state_q == ST_B);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign fifo_rd_en = w_hs;

    assign axi.M_AXI_AWID    = 4'h0;
    assign axi.M_AXI_AWADDR  = awaddr_q;
    assign axi.M_AXI_AWLEN   = awlen_q;
    assign axi.M_AXI_AWSIZE  = 3'b010;
    assign axi.M_AXI_AWBURST = 2'b01;
    assign axi.M_AXI_AWVALID = (state_q == ST_AW);
    assign axi.M_AXI_WDATA   = fifo_dout;
    assign axi.M_AXI_WSTRB   = 4'hF;
    assign axi.M_AXI_WLAST   = (state_q == ST_W) && (beat_q == awlen_q);
    assign axi.M_AXI_WVALID  = w_valid;
    assign axi.M_AXI_BREADY  = (state_q == ST_B);

    assign unused_bid = ^axi.M_AXI_BID;
endmodule

// File: tb/tb_rsa_result_axi_writer.sv
// Directed bench for rsa_result_axi_writer: FWFT FIFO model plus an AXI write slave with optional backpressure.
module tb_rsa_result_axi_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        busy, done, err;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;

    rsa_result_axi_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    rsa_result_axi_writer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .err(err),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Stimulus-side controls (written only by the main sequence)
    logic [31:0] fmem [0:1023];
    int fwr = 0;
    int rnd_mode = 0;
    int err_burst = -1;
    int hold_at = -1;
    int start_cyc = 0;

    // Slave/monitor state (written only by the monitor)
    int frd = 0;
    bit pop_pend = 0;
    int b_owed = 0;
    bit b_hs = 0;
    int hold_cnt = 0;
    int hold_used = -1;
    int aw_n = 0, w_n = 0, b_n = 0, done_n = 0, aw_rise_n = 0;
    int aw_rise_cyc = 0, b_cyc = 0, done_cyc = 0;
    int viol_aw = 0, viol_wempty = 0, viol_pop = 0;
    bit aw_pend = 0, awv_prev = 0;
    logic [31:0] aw_hold_addr = '0;
    logic [7:0]  aw_hold_len = '0;
    logic [31:0] aw_addr_log [0:255];
    logic [7:0]  aw_len_log  [0:255];
    int          aw_cyc_log  [0:255];
    logic [31:0] w_data_log  [0:1023];
    logic        w_last_log  [0:1023];

    always begin
        @(negedge clk);
        if (pop_pend) frd = frd + 1;
        pop_pend = 0;
        if (rst) b_owed = 0;
        if (hold_at >= 0 && w_n == hold_at && hold_used != hold_at) begin
            hold_cnt  = 5;
            hold_used = hold_at;
        end
        axi.M_AXI_AWREADY = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.M_AXI_WREADY  = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!(axi.M_AXI_BVALID === 1'b1 && !b_hs))
            axi.M_AXI_BVALID = (b_owed > 0) && ((rnd_mode == 0) || ($urandom_range(0, 2) == 0));
        b_hs = 0;
        axi.M_AXI_BRESP = (b_n == err_burst) ? 2'b10 : 2'b00;
        axi.M_AXI_BID   = 4'h0;
        fifo_empty = (frd == fwr) || (hold_cnt > 0);
        if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
        fifo_dout = fmem[frd];
        #1;
        if (aw_pend && !(axi.M_AXI_AWVALID === 1'b1 && axi.M_AXI_AWADDR === aw_hold_addr &&
                         axi.M_AXI_AWLEN === aw_hold_len)) viol_aw++;
        aw_pend      = (axi.M_AXI_AWVALID === 1'b1) && (axi.M_AXI_AWREADY !== 1'b1);
        aw_hold_addr = axi.M_AXI_AWADDR;
        aw_hold_len  = axi.M_AXI_AWLEN;
        if (axi.M_AXI_AWVALID === 1'b1 && !awv_prev) begin
            aw_rise_n++;
            aw_rise_cyc = cyc;
        end
        awv_prev = (axi.M_AXI_AWVALID === 1'b1);
        if (axi.M_AXI_AWVALID === 1'b1 && axi.M_AXI_AWREADY === 1'b1) begin
            aw_addr_log[aw_n] = axi.M_AXI_AWADDR;
            aw_len_log[aw_n]  = axi.M_AXI_AWLEN;
            aw_cyc_log[aw_n]  = aw_rise_cyc;
            aw_n++;
        end
        if (fifo_empty && axi.M_AXI_WVALID === 1'b1) viol_wempty++;
        if (fifo_rd_en !== (axi.M_AXI_WVALID && axi.M_AXI_WREADY)) viol_pop++;
        if (axi.M_AXI_WVALID === 1'b1 && axi.M_AXI_WREADY === 1'b1) begin
            w_data_log[w_n] = axi.M_AXI_WDATA;
            w_last_log[w_n] = axi.M_AXI_WLAST;
            w_n++;
            if (axi.M_AXI_WLAST === 1'b1) b_owed++;
        end
        if (fifo_rd_en === 1'b1) pop_pend = 1;
        if (axi.M_AXI_BVALID === 1'b1 && axi.M_AXI_BREADY === 1'b1) begin
            b_n++;
            b_owed--;
            b_hs  = 1;
            b_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic push_words(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            fmem[fwr] = first + 32'(i);
            fwr = fwr + 1;
        end
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [15:0] c);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_cnt = c;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_n != d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk_cnt++;
        if ({busy, done, err, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_WLAST, axi.M_AXI_BREADY, fifo_rd_en} !== 8'h00)
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {busy, done, err, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_WLAST, axi.M_AXI_BREADY, fifo_rd_en});
        else pass_cnt++;
        chk_cnt++;
        if ({axi.M_AXI_AWADDR, axi.M_AXI_AWLEN} !== 40'h0)
            $display("FAIL reset_aw: got addr %h len %h required 0/0", axi.M_AXI_AWADDR, axi.M_AXI_AWLEN);
        else pass_cnt++;
        chk_cnt++;
        if ({axi.M_AXI_AWID, axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST, axi.M_AXI_WSTRB} !== {4'h0, 3'b010, 2'b01, 4'hF})
            $display("FAIL const_fields: got id %h size %b burst %b strb %h required 0/010/01/f",
                     axi.M_AXI_AWID, axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST, axi.M_AXI_WSTRB);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        int a0, w0, f0, d0, bad;
        bit ok;
        a0 = aw_n; w0 = w_n; f0 = frd; d0 = done_n; bad = 0;
        push_words(8, 32'd1);
        start_xfer(32'h100, 16'd8);
        wait_done(d0, 200, ok);
        chk_cnt++;
        if (!ok) $display("FAIL single_timeout: done not seen in 200 cycles"); else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_at_done: got %b required 0", busy); else pass_cnt++;
        chk_cnt++;
        if (aw_n - a0 != 1 || aw_addr_log[a0] !== 32'h100 || aw_len_log[a0] !== 8'd7)
            $display("FAIL single_aw: got n=%0d addr %h len %0d required 1/100/7", aw_n - a0, aw_addr_log[a0], aw_len_log[a0]);
        else pass_cnt++;
        chk_cnt++;
        if (aw_cyc_log[a0] - start_cyc != 2)
            $display("FAIL start_to_awvalid: got %0d cycles required 2", aw_cyc_log[a0] - start_cyc);
        else pass_cnt++;
        for (int i = 0; i < 8; i++)
            if (w_data_log[w0 + i] !== 32'(i + 1) || w_last_log[w0 + i] !== (i == 7)) bad++;
        chk_cnt++;
        if (w_n - w0 != 8 || bad != 0) $display("FAIL single_wdata: got %0d beats %0d bad required 8/0", w_n - w0, bad);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc - b_cyc != 1) $display("FAIL bresp_to_done: got %0d cycles required 1", done_cyc - b_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0 || frd - f0 != 8 || frd != fwr)
            $display("FAIL single_err_fifo: got err %b pops %0d required 0/8 and empty", err, frd - f0);
        else pass_cnt++;
        @(negedge clk);
        #2;
        chk_cnt++;
        if (done !== 1'b0 || done_n - d0 != 1) $display("FAIL done_pulse: got done %b pulses %0d required 0/1", done, done_n - d0);
        else pass_cnt++;
    endtask

    task automatic test_burst_split();
        int a0, w0, f0, d0, bad;
        bit ok;
        a0 = aw_n; w0 = w_n; f0 = frd; d0 = done_n; bad = 0;
        push_words(40, 32'h1000);
        start_xfer(32'h0, 16'd40);
        wait_done(d0, 400, ok);
        chk_cnt++;
        if (!ok) $display("FAIL split_timeout: done not seen in 400 cycles"); else pass_cnt++;
        chk_cnt++;
        if (aw_n - a0 != 3 || aw_addr_log[a0] !== 32'h000 || aw_len_log[a0] !== 8'd15 ||
            aw_addr_log[a0 + 1] !== 32'h040 || aw_len_log[a0 + 1] !== 8'd15 ||
            aw_addr_log[a0 + 2] !== 32'h080 || aw_len_log[a0 + 2] !== 8'd7)
            $display("FAIL split_aw: got n=%0d %h/%0d %h/%0d %h/%0d required 3 000/15 040/15 080/7", aw_n - a0,
                     aw_addr_log[a0], aw_len_log[a0], aw_addr_log[a0 + 1], aw_len_log[a0 + 1], aw_addr_log[a0 + 2], aw_len_log[a0 + 2]);
        else pass_cnt++;
        for (int i = 0; i < 40; i++)
            if (w_data_log[w0 + i] !== 32'h1000 + 32'(i) || w_last_log[w0 + i] !== (i == 15 || i == 31 || i == 39)) bad++;
        chk_cnt++;
        if (bad != 0 || frd - f0 != 40) $display("FAIL split_data: got %0d bad %0d pops required 0/40", bad, frd - f0);
        else pass_cnt++;
    endtask

    task automatic test_4k_boundary();
        int a0, w0, d0, bad;
        bit ok;
        a0 = aw_n; w0 = w_n; d0 = done_n; bad = 0;
        push_words(6, 32'hD0);
        start_xfer(32'hFF8, 16'd6);
        wait_done(d0, 200, ok);
        chk_cnt++;
        if (!ok) $display("FAIL 4k_timeout: done not seen in 200 cycles"); else pass_cnt++;
        chk_cnt++;
        if (aw_n - a0 != 2 || aw_addr_log[a0] !== 32'hFF8 || aw_len_log[a0] !== 8'd1 ||
            aw_addr_log[a0 + 1] !== 32'h1000 || aw_len_log[a0 + 1] !== 8'd3)
            $display("FAIL 4k_aw: got n=%0d %h/%0d %h/%0d required 2 ff8/1 1000/3", aw_n - a0,
                     aw_addr_log[a0], aw_len_log[a0], aw_addr_log[a0 + 1], aw_len_log[a0 + 1]);
        else pass_cnt++;
        for (int i = 0; i < 6; i++)
            if (w_data_log[w0 + i] !== 32'hD0 + 32'(i) || w_last_log[w0 + i] !== (i == 1 || i == 5)) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL 4k_data: got %0d bad beats required 0", bad); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int a0, w0, f0, d0, bad, va, ve, vp;
        bit ok;
        a0 = aw_n; w0 = w_n; f0 = frd; d0 = done_n; bad = 0;
        va = viol_aw; ve = viol_wempty; vp = viol_pop;
        push_words(20, 32'h5000);
        rnd_mode = 1;
        hold_at = w0 + 5;
        start_xfer(32'h300, 16'd20);
        wait_done(d0, 2000, ok);
        rnd_mode = 0;
        chk_cnt++;
        if (!ok) $display("FAIL bp_timeout: done not seen in 2000 cycles"); else pass_cnt++;
        chk_cnt++;
        if (viol_aw != va) $display("FAIL bp_aw_stable: got %0d violations required 0", viol_aw - va); else pass_cnt++;
        chk_cnt++;
        if (viol_wempty != ve) $display("FAIL bp_wvalid_empty: got %0d violations required 0", viol_wempty - ve); else pass_cnt++;
        chk_cnt++;
        if (viol_pop != vp) $display("FAIL bp_pop_handshake: got %0d violations required 0", viol_pop - vp); else pass_cnt++;
        chk_cnt++;
        if (hold_used != w0 + 5) $display("FAIL bp_underflow_applied: got %0d required %0d", hold_used, w0 + 5); else pass_cnt++;
        for (int i = 0; i < 20; i++)
            if (w_data_log[w0 + i] !== 32'h5000 + 32'(i) || w_last_log[w0 + i] !== (i == 15 || i == 19)) bad++;
        chk_cnt++;
        if (bad != 0 || frd - f0 != 20 || aw_n - a0 != 2 || aw_addr_log[a0 + 1] !== 32'h340 || aw_len_log[a0 + 1] !== 8'd3)
            $display("FAIL bp_data: got %0d bad %0d pops %0d bursts 2nd %h/%0d required 0/20/2 340/3",
                     bad, frd - f0, aw_n - a0, aw_addr_log[a0 + 1], aw_len_log[a0 + 1]);
        else pass_cnt++;
    endtask

    task automatic test_error();
        int a0, f0, b0, d0;
        bit ok;
        a0 = aw_n; f0 = frd; b0 = b_n; d0 = done_n;
        push_words(40, 32'h7000);
        err_burst = b0 + 1;
        start_xfer(32'h0, 16'd40);
        wait_done(d0, 400, ok);
        chk_cnt++;
        if (!ok) $display("FAIL err_timeout: done not seen in 400 cycles"); else pass_cnt++;
        chk_cnt++;
        if (aw_n - a0 != 3 || b_n - b0 != 3 || frd - f0 != 40)
            $display("FAIL err_complete: got %0d bursts %0d resp %0d pops required 3/3/40", aw_n - a0, b_n - b0, frd - f0);
        else pass_cnt++;
        @(negedge clk);
        #2;
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b required 1", err); else pass_cnt++;
        err_burst = -1;
        d0 = done_n;
        push_words(2, 32'h7100);
        start_xfer(32'h500, 16'd2);
        #2;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL err_clear_on_start: got %b required 0", err); else pass_cnt++;
        wait_done(d0, 200, ok);
        chk_cnt++;
        if (!ok || err !== 1'b0) $display("FAIL err_clean_xfer: got done %b err %b required 1/0", ok, err); else pass_cnt++;
    endtask

    task automatic test_edge_cases();
        int a0, w0, f0, d0, r0;
        bit ok;
        d0 = done_n; r0 = aw_rise_n;
        start_xfer(32'h40, 16'd0);
        wait_done(d0, 20, ok);
        chk_cnt++;
        if (!ok || done_cyc - start_cyc != 1 || aw_rise_n != r0)
            $display("FAIL zero_count: got done %b latency %0d awvalids %0d required 1/1/0", ok, done_cyc - start_cyc, aw_rise_n - r0);
        else pass_cnt++;

        a0 = aw_n; f0 = frd; d0 = done_n;
        push_words(8, 32'hB0);
        start_xfer(32'h600, 16'd8);
        #2;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", busy); else pass_cnt++;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h900; word_cnt = 16'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 200, ok);
        repeat (10) @(negedge clk);
        #2;
        chk_cnt++;
        if (!ok || done_n - d0 != 1 || aw_n - a0 != 1 || aw_addr_log[a0] !== 32'h600 || frd - f0 != 8)
            $display("FAIL start_while_busy: got done %0d bursts %0d addr %h pops %0d required 1/1/600/8",
                     done_n - d0, aw_n - a0, aw_addr_log[a0], frd - f0);
        else pass_cnt++;

        a0 = aw_n; w0 = w_n; d0 = done_n;
        push_words(1, 32'hC0);
        start_xfer(32'h202, 16'd1);
        wait_done(d0, 100, ok);
        chk_cnt++;
        if (!ok || aw_addr_log[a0] !== 32'h200 || aw_len_log[a0] !== 8'd0 || w_data_log[w0] !== 32'hC0 || w_last_log[w0] !== 1'b1)
            $display("FAIL low_bits_single_beat: got addr %h len %0d data %h last %b required 200/0/c0/1",
                     aw_addr_log[a0], aw_len_log[a0], w_data_log[w0], w_last_log[w0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int a0, w0, d0, bad;
        bit ok;
        w0 = w_n; ok = 0; bad = 0;
        push_words(8, 32'hA0);
        start_xfer(32'h700, 16'd8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (w_n - w0 >= 3) begin
                ok = 1;
                break;
            end
        end
        chk_cnt++;
        if (!ok) $display("FAIL rstmid_reach_beat3: beat 3 not reached in 50 cycles"); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk_cnt++;
        if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, done, fifo_rd_en} !== 6'b0)
            $display("FAIL rstmid_outputs: got %b required 000000",
                     {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, busy, done, fifo_rd_en});
        else pass_cnt++;
        rst = 1'b0;
        a0 = aw_n; w0 = w_n; d0 = done_n;
        start_xfer(32'h800, 16'd5);
        wait_done(d0, 200, ok);
        for (int i = 0; i < 5; i++)
            if (w_data_log[w0 + i] !== 32'hA3 + 32'(i) || w_last_log[w0 + i] !== (i == 4)) bad++;
        chk_cnt++;
        if (!ok || aw_n - a0 != 1 || aw_addr_log[a0] !== 32'h800 || aw_len_log[a0] !== 8'd4 || bad != 0 || frd != fwr)
            $display("FAIL rstmid_restart: got done %b bursts %0d addr %h len %0d bad %0d required 1/1/800/4/0",
                     ok, aw_n - a0, aw_addr_log[a0], aw_len_log[a0], bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_burst_split();
        test_4k_boundary();
        test_backpressure();
        test_error();
        test_edge_cases();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
